riscv_aes_inv_cipher: RTL and testbench
=======================================

# riscv_aes_inv_cipher

Iterative AES-128 decryptor, the inverse of the pipelined encryption datapath in the RISC-V AES extension. It accepts one ciphertext block plus the cipher key, derives the last round key on-chip, then runs the ten inverse rounds one per cycle while rolling the key schedule backwards. It sits beside the encryptor and uses the same start-pulse and address-tag interface style, so the core-side glue is shared.

## Interface
- No parameters; block size and key size are fixed at 128 bits.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_aes_in  in  1  request pulse; accepted when busy=0
- datain  in  128  ciphertext; bits 127:120 = byte 0, FIPS-197 column-major order
- key  in  128  cipher key (round key 0), same byte order
- addrin  in  32  tag captured with the request
- busy  out  1  high from the accept edge until the result edge
- start_aes_out  out  1  one-cycle completion pulse
- dataout  out  128  plaintext; held until the next completion
- addrout  out  32  tag of the request that produced dataout

## Operation
- States: IDLE, KEYEXP, WHITEN, ROUND, DONE.
- IDLE/DONE with start_aes_in=1: capture datain into state, key into rk, addrin into tag; rnd<=1; go to KEYEXP. Otherwise DONE returns to IDLE.
- KEYEXP, 10 cycles: rk <= forward_expand(rk, rcon[rnd]); rnd++. After the 10th edge, rk = rk10.
- WHITEN, 1 cycle: state <= state ^ rk; rk <= reverse_expand(rk10, rcon[10]) = rk9; rnd<=9.
- ROUND, 10 cycles: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk). InvMixColumns is omitted on the 10th round.
  - Rounds 1-9: rk <= reverse_expand(rk, rcon[rnd]); rnd--.
  - Round 10 uses rk0; rk is unchanged.
- After round 10: dataout <= result, addrout <= tag, go to DONE.
- reverse_expand: w3'=w3^w2; w2'=w2^w1; w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^{rcon,24'h0}.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- start_aes_in while busy=1 is ignored: no queueing and no error.

## Timing
- Reset values: busy=0, start_aes_out=0, dataout=0, addrout=0, FSM=IDLE.
- Accept edge T0. KEYEXP occupies T1-T10, WHITEN T11, ROUND T12-T21.
- At T21: dataout and addrout update, and start_aes_out rises for exactly one cycle (the DONE cycle).
- Latency is 21 cycles, accept edge to output edge.
- busy is high from T0 through T21 and low in the DONE cycle.
- A start in the DONE cycle is accepted, so back-to-back blocks take one per 22 cycles.
- rst_n low at any time, including mid-ROUND, aborts immediately and returns all outputs to reset values. No pulse is emitted for the aborted block.
- datain, key and addrin are sampled only at the accept edge. Changes afterwards have no effect.

## Structure
- riscv_aes_pkg holds:
  - sbox and inv_sbox functions
  - rcon lookup
  - state typedef (4x4 bytes)
  - gf_mul2, InvMixColumns column function
  - FSM state enum
- Sub-module riscv_aes_inv_round is combinational: state, rk and a last flag in; next state out. It instantiates 16 inv_sbox lookups.
- The top level holds the FSM, counters, registers and the forward/reverse key step (4 sbox lookups, shared by both directions through a mux).

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, datain 69c4e0d86a7b0430d8cdb78070b4c55a, addrin 32'h1000 -> 21 cycles later dataout 00112233445566778899aabbccddeeff, addrout 32'h1000, single start_aes_out pulse.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, datain 3925841d02dc09fbdc118597196a0b32 -> dataout 3243f6a8885a308d313198a2e0370734. Probe rk after T10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Start pulsed again at T5 with different datain -> ignored; the first result is unchanged and only one output pulse occurs.
- Back-to-back: second start in the DONE cycle with C.1 vectors after the App. B block -> both results correct; pulses 22 cycles apart.
- rst_n asserted at T15 and released, then a new request -> no pulse for the aborted block; outputs read 0; the new block decrypts correctly.
- Round-trip: 1000 random key/plaintext pairs encrypted by the team's encryptor model and fed in -> dataout equals the original plaintext and addrout equals the tag.

Source files
------------

// File: rtl/riscv_aes_pkg.sv
// riscv_aes_pkg
//   Shared AES definitions for the inverse cipher slice: forward and inverse
//   S-box lookups, round constants, the 4x4 byte state type, GF(2^8)
//   doubling, the InvMixColumns column transform and the FSM state encoding.
//   Byte order everywhere: bits 127:120 are byte 0, column-major, so
//   state[c][r] is row r of column c.
package riscv_aes_pkg;

  // 4 columns x 4 rows x 8 bits; [0][0] sits in the top byte (byte 0).
  typedef logic [0:3][0:3][7:0] aes_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_WHITEN,
    ST_ROUND,
    ST_DONE
  } fsm_state_t;

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[x];
  endfunction

  // Round constants for key-schedule steps 1..10; other indices return 0.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; col[31:24] is row 0.
  // Coefficients 9/11/13/14 are built from the x2/x4/x8 doubling chain.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0]  a   [0:3];
    logic [7:0]  m9  [0:3];
    logic [7:0]  m11 [0:3];
    logic [7:0]  m13 [0:3];
    logic [7:0]  m14 [0:3];
    logic [7:0]  x2, x4, x8;
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = gf_mul2(a[i]);
      x4     = gf_mul2(x2);
      x8     = gf_mul2(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = m14[r] ^ m11[(r+1)%4] ^ m13[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_aes_inv_cipher_if.sv
// riscv_aes_inv_cipher_if
//   Request/response bundle of the inverse cipher, same shape as the
//   encryptor's so the core-side glue is shared.
//   master : drives start_aes_in/datain/key/addrin, receives the rest
//   slave  : the cipher itself
interface riscv_aes_inv_cipher_if;
  logic         start_aes_in;
  logic [127:0] datain;
  logic [127:0] key;
  logic [31:0]  addrin;
  logic         busy;
  logic         start_aes_out;
  logic [127:0] dataout;
  logic [31:0]  addrout;

  modport master (
    output start_aes_in, datain, key, addrin,
    input  busy, start_aes_out, dataout, addrout
  );

  modport slave (
    input  start_aes_in, datain, key, addrin,
    output busy, start_aes_out, dataout, addrout
  );
endinterface

// File: rtl/riscv_aes_inv_round.sv
// riscv_aes_inv_round
//   Combinational inverse round:
//     state_out = InvMixColumns(InvSubBytes(InvShiftRows(state_in)) ^ rk)
//   with InvMixColumns bypassed when last=1.
//   Ports: state_in (128), rk (128 round key), last (1), state_out (128).
module riscv_aes_inv_round
  import riscv_aes_pkg::*;
(
  input  aes_state_t   state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output aes_state_t   state_out
);

  aes_state_t   sub_st;
  logic [127:0] added;

  genvar gi;

  // InvShiftRows moves row r right by r columns, so output column c of
  // row r comes from input column (c - r) mod 4. The S-box is bytewise,
  // so shift and substitution fold into one lookup per byte.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_inv_sub
      localparam int COL = gi / 4;
      localparam int ROW = gi % 4;
      localparam int SRC = (COL + 4 - ROW) % 4;
      assign sub_st[COL][ROW] = inv_sbox(state_in[SRC][ROW]);
    end
  endgenerate

  assign added = sub_st ^ rk;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_inv_mix
      assign state_out[gi] = last ? added[127-32*gi -: 32]
                                  : inv_mix_column(added[127-32*gi -: 32]);
    end
  endgenerate

endmodule

// File: rtl/riscv_aes_inv_cipher.sv
// riscv_aes_inv_cipher
//   Iterative AES-128 decryptor. A request captures ciphertext, cipher key
//   and tag; the key schedule is run forward ten steps to reach rk10, the
//   state is whitened with rk10, then ten inverse rounds run one per cycle
//   while the schedule is rolled back one step per round.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : slave side of riscv_aes_inv_cipher_if
//             (start_aes_in/datain/key/addrin in,
//              busy/start_aes_out/dataout/addrout out)
//   Latency is 21 cycles from accept edge to result edge; a new request is
//   accepted in the DONE cycle, giving one block per 22 cycles.
module riscv_aes_inv_cipher
  import riscv_aes_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  riscv_aes_inv_cipher_if.slave bus
);

  fsm_state_t   fsm_reg, fsm_next;
  aes_state_t   state_reg;
  logic [127:0] rk_reg;
  logic [3:0]   rnd_reg;
  logic [31:0]  tag_reg;
  logic [127:0] dataout_reg;
  logic [31:0]  addrout_reg;

  logic         accept;
  logic         busy_out;
  logic         done_pulse;
  aes_state_t   round_out;

  // ---------------------------------------------------------------------
  // Key step, shared by forward (KEYEXP) and reverse (WHITEN/ROUND).
  // Forward SubWord reads w3; reverse reads the recovered w3' = w3 ^ w2.
  // ---------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic         key_rev;
  logic [3:0]   rc_idx;
  logic [31:0]  rc_word;
  logic [31:0]  sub_src;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  r0, r1, r2, r3;
  logic [127:0] key_next;

  assign w0 = rk_reg[127:96];
  assign w1 = rk_reg[95:64];
  assign w2 = rk_reg[63:32];
  assign w3 = rk_reg[31:0];

  assign key_rev  = (fsm_reg != ST_KEYEXP);
  // rnd_reg is 11 on entry to WHITEN, but that step must undo rcon[10].
  assign rc_idx   = (fsm_reg == ST_WHITEN) ? 4'd10 : rnd_reg;
  assign rc_word  = {rcon(rc_idx), 24'h0};
  assign sub_src  = key_rev ? (w3 ^ w2) : w3;
  assign rot_word = {sub_src[23:0], sub_src[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key_sbox
      assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
    end
  endgenerate

  assign f0 = w0 ^ sub_word ^ rc_word;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign r3 = w3 ^ w2;
  assign r2 = w2 ^ w1;
  assign r1 = w1 ^ w0;
  assign r0 = w0 ^ sub_word ^ rc_word;

  assign key_next = key_rev ? {r0, r1, r2, r3} : {f0, f1, f2, f3};

  // ---------------------------------------------------------------------
  // Inverse round datapath; rnd_reg reaches 0 on the tenth round, which
  // uses rk0 and skips InvMixColumns.
  // ---------------------------------------------------------------------
  riscv_aes_inv_round u_inv_round (
    .state_in  (state_reg),
    .rk        (rk_reg),
    .last      (rnd_reg == 4'd0),
    .state_out (round_out)
  );

  assign accept = bus.start_aes_in &&
                  ((fsm_reg == ST_IDLE) || (fsm_reg == ST_DONE));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg <= ST_IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  // FSM: next state
  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      ST_IDLE:   if (accept) fsm_next = ST_KEYEXP;
      ST_KEYEXP: if (rnd_reg == 4'd10) fsm_next = ST_WHITEN;
      ST_WHITEN: fsm_next = ST_ROUND;
      ST_ROUND:  if (rnd_reg == 4'd0) fsm_next = ST_DONE;
      ST_DONE:   fsm_next = accept ? ST_KEYEXP : ST_IDLE;
      default:   fsm_next = ST_IDLE;
    endcase
  end

  // FSM: outputs. DONE lasts exactly one cycle, so it is the pulse.
  always_comb begin
    busy_out   = 1'b0;
    done_pulse = 1'b0;
    case (fsm_reg)
      ST_KEYEXP, ST_WHITEN, ST_ROUND: busy_out   = 1'b1;
      ST_DONE:                        done_pulse = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= '0;
      rk_reg      <= '0;
      rnd_reg     <= '0;
      tag_reg     <= '0;
      dataout_reg <= '0;
      addrout_reg <= '0;
    end else begin
      case (fsm_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_reg <= bus.datain;
            rk_reg    <= bus.key;
            tag_reg   <= bus.addrin;
            rnd_reg   <= 4'd1;
          end
        end
        ST_KEYEXP: begin
          rk_reg  <= key_next;
          rnd_reg <= rnd_reg + 4'd1;
        end
        ST_WHITEN: begin
          state_reg <= state_reg ^ rk_reg;
          rk_reg    <= key_next;
          rnd_reg   <= 4'd9;
        end
        ST_ROUND: begin
          state_reg <= round_out;
          if (rnd_reg != 4'd0) begin
            rk_reg  <= key_next;
            rnd_reg <= rnd_reg - 4'd1;
          end else begin
            dataout_reg <= round_out;
            addrout_reg <= tag_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = busy_out;
  assign bus.start_aes_out = done_pulse;
  assign bus.dataout       = dataout_reg;
  assign bus.addrout       = addrout_reg;

endmodule

// File: tb/tb_riscv_aes_inv_cipher.sv
// tb_riscv_aes_inv_cipher
//   Drives directed FIPS-197 vectors and random blocks through the inverse
//   cipher. Random ciphertexts come from a forward AES-128 model whose
//   S-box is derived from GF(2^8) inversion plus the affine map, so the
//   expected plaintext is the original random plaintext.
module tb_riscv_aes_inv_cipher;

  logic clk;
  logic rst_n;

  riscv_aes_inv_cipher_if bus ();

  riscv_aes_inv_cipher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.start_aes_out === 1'b1) pulse_cnt <= pulse_cnt + 1;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  logic [7:0] sbox_m [0:255];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0]  inv;
    logic [15:0] bb;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      bb = {inv, inv};
      sbox_m[x] = inv ^ bb[14 -: 8] ^ bb[13 -: 8] ^ bb[12 -: 8] ^ bb[11 -: 8] ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w   [0:43];
    logic [7:0]   st  [0:15];
    logic [7:0]   tmp [0:15];
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_m[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          tmp[r + 4*c] = st[r + 4*((c + r) % 4)];
      for (int i = 0; i < 16; i++) st[i] = tmp[i];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
          st[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // ------------------------------------------------------------------
  // Checking and driving
  // ------------------------------------------------------------------
  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at #1 after a posedge while the DUT is idle or in DONE; returns
  // #1 after the accept edge. Inputs are scrambled afterwards so only the
  // values present at the accept edge can influence the result.
  task automatic send_req(input logic [127:0] ct, input logic [127:0] k, input logic [31:0] tag);
    bus.datain       = ct;
    bus.key          = k;
    bus.addrin       = tag;
    bus.start_aes_in = 1'b1;
    @(posedge clk); #1;
    bus.start_aes_in = 1'b0;
    bus.datain       = {$urandom, $urandom, $urandom, $urandom};
    bus.key          = {$urandom, $urandom, $urandom, $urandom};
    bus.addrin       = $urandom;
  endtask

  // Waits (bounded) for the completion pulse; returns #1 into the DONE cycle.
  task automatic wait_result(input string name, input logic [127:0] pt_exp,
                             input logic [31:0] tag_exp, input bit do_probe,
                             input logic [127:0] rk10_exp, input int inject_at);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    check_val({name, "_busy_hi"}, 128'(bus.busy), 128'd1);
    while (!got && lat < 60) begin
      if (bus.start_aes_out === 1'b1) begin
        got = 1'b1;
      end else begin
        if (do_probe && lat == 10) check_val({name, "_rk10"}, dut.rk_reg, rk10_exp);
        if (lat == inject_at) begin
          bus.start_aes_in = 1'b1;
          bus.datain       = {$urandom, $urandom, $urandom, $urandom};
          bus.addrin       = 32'hdead_beef;
        end
        if (lat == inject_at + 1) bus.start_aes_in = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
    end
    last_pulse_cyc = cyc;
    check_val({name, "_latency"}, 128'(lat), 128'd21);
    check_val({name, "_dataout"}, bus.dataout, pt_exp);
    check_val({name, "_addrout"}, 128'(bus.addrout), 128'(tag_exp));
    check_val({name, "_busy_lo"}, 128'(bus.busy), 128'd0);
    $display("txn %s tag=%h lat=%0d dataout=%h", name, bus.addrout, lat, bus.dataout);
  endtask

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    int p0;
    int c0;
    logic [127:0] pt, k, ct;
    logic [31:0]  tag;

    rst_n            = 1'b0;
    bus.start_aes_in = 1'b0;
    bus.datain       = '0;
    bus.key          = '0;
    bus.addrin       = '0;
    build_sbox();

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 128'(bus.busy), 128'd0);
    check_val("rst_pulse", 128'(bus.start_aes_out), 128'd0);
    check_val("rst_dataout", bus.dataout, 128'd0);
    check_val("rst_addrout", 128'(bus.addrout), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1
    p0 = pulse_cnt;
    send_req(C1_CT, C1_KEY, 32'h1000);
    wait_result("c1", C1_PT, 32'h1000, 1'b0, '0, -1);
    @(posedge clk); #1;
    check_val("c1_pulse_width", 128'(bus.start_aes_out), 128'd0);
    check_val("c1_pulse_count", 128'(pulse_cnt - p0), 128'd1);

    // FIPS-197 App. B with key-schedule probe, then C.1 back-to-back
    send_req(B_CT, B_KEY, 32'h2000);
    wait_result("appb", B_PT, 32'h2000, 1'b1, B_RK10, -1);
    c0 = last_pulse_cyc;
    send_req(C1_CT, C1_KEY, 32'h3000);
    wait_result("b2b_c1", C1_PT, 32'h3000, 1'b0, '0, -1);
    check_val("b2b_gap", 128'(last_pulse_cyc - c0), 128'd22);
    @(posedge clk); #1;

    // Start pulsed at T5 while busy is ignored
    p0 = pulse_cnt;
    send_req(B_CT, B_KEY, 32'h4000);
    wait_result("busy_start", B_PT, 32'h4000, 1'b0, '0, 4);
    repeat (30) @(posedge clk);
    #1;
    check_val("busy_start_pulses", 128'(pulse_cnt - p0), 128'd1);
    check_val("busy_start_hold", bus.dataout, B_PT);

    // Reset at T15 aborts the block
    p0 = pulse_cnt;
    send_req(C1_CT, C1_KEY, 32'h5000);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 128'(bus.busy), 128'd0);
    check_val("abort_pulse", 128'(bus.start_aes_out), 128'd0);
    check_val("abort_dataout", bus.dataout, 128'd0);
    check_val("abort_addrout", 128'(bus.addrout), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_val("abort_no_pulse", 128'(pulse_cnt - p0), 128'd0);
    check_val("abort_dataout_hold", bus.dataout, 128'd0);
    send_req(B_CT, B_KEY, 32'h6000);
    wait_result("after_abort", B_PT, 32'h6000, 1'b0, '0, -1);

    // Random round trips, mixing back-to-back and idle gaps
    for (int n = 0; n < 1000; n++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      k   = {$urandom, $urandom, $urandom, $urandom};
      tag = $urandom;
      ct  = aes_enc(pt, k);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_req(ct, k, tag);
      wait_result($sformatf("rand%0d", n), pt, tag, 1'b0, '0, -1);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
